// File: rtl/chip_spreading.sv
// Serial-bit to 32-chip DSSS spreader: assembles LSB-first 4-bit symbols,
// buffers them in a small FIFO and emits each symbol's PN chip word serially.
module chip_spreading #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bit_in,
  input  logic bit_in_valid,
  output logic chip_out,
  output logic chip_out_valid,
  output logic overflow,
  output logic busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

  typedef enum logic {IDLE, SEND} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_nib;
  logic [1:0]  r_bitcnt;
  logic        r_prev_vld;
  logic [3:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic        r_ovf;
  logic [31:0] r_sr;
  logic [4:0]  r_chipcnt;
  logic        r_vld;

  logic [AW:0] w_count;
  logic        w_empty, w_full, w_flush, w_push, w_push_ok, w_pop;
  logic [3:0]  w_push_sym;
  logic [31:0] w_word;

  // Chip word with c0 in the MSB so the emitter shifts left.
  function automatic logic [31:0] chip_word(input logic [3:0] sym);
    case (sym)
      4'h0:    chip_word = 32'hD9C3522E;
      4'h1:    chip_word = 32'hED9C3522;
      4'h2:    chip_word = 32'h2ED9C352;
      4'h3:    chip_word = 32'h22ED9C35;
      4'h4:    chip_word = 32'h522ED9C3;
      4'h5:    chip_word = 32'h3522ED9C;
      4'h6:    chip_word = 32'hC3522ED9;
      4'h7:    chip_word = 32'h9C3522ED;
      4'h8:    chip_word = 32'h8C96077B;
      4'h9:    chip_word = 32'hB8C96077;
      4'hA:    chip_word = 32'h7B8C9607;
      4'hB:    chip_word = 32'h77B8C960;
      4'hC:    chip_word = 32'h077B8C96;
      4'hD:    chip_word = 32'h6077B8C9;
      4'hE:    chip_word = 32'h96077B8C;
      default: chip_word = 32'hC96077B8;
    endcase
  endfunction

  assign w_count   = r_wptr - r_rptr;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == DEPTH_L);
  assign w_flush   = r_prev_vld && !bit_in_valid && (r_bitcnt != 2'd0);
  assign w_push    = (bit_in_valid && (r_bitcnt == 2'd3)) || w_flush;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_word    = chip_word(r_mem[r_rptr[AW-1:0]]);

  // Held nibble bits above bitcnt are already zero, which gives the flush padding.
  always_comb begin
    w_push_sym = r_nib;
    if (bit_in_valid && (r_bitcnt == 2'd3)) w_push_sym = {bit_in, r_nib[2:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nib      <= '0;
      r_bitcnt   <= '0;
      r_prev_vld <= 1'b0;
      r_wptr     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_prev_vld <= bit_in_valid;
      if (bit_in_valid) begin
        r_bitcnt <= r_bitcnt + 2'd1;
        if (r_bitcnt == 2'd3) r_nib <= '0;
        else                  r_nib[r_bitcnt] <= bit_in;
      end else if (w_flush) begin
        r_bitcnt <= '0;
        r_nib    <= '0;
      end
      if (w_push_ok) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= w_push_sym;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // A pop on the last chip reloads on the same edge, so symbols run back to back.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = SEND;
        end
      end
      SEND: begin
        if (r_chipcnt == 5'd31) begin
          if (!w_empty) w_pop  = 1'b1;
          else          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr      <= '0;
      r_chipcnt <= '0;
      r_vld     <= 1'b0;
      r_rptr    <= '0;
    end else if (w_pop) begin
      r_sr      <= w_word;
      r_chipcnt <= '0;
      r_vld     <= 1'b1;
      r_rptr    <= r_rptr + (AW+1)'(1);
    end else if (r_state == SEND) begin
      if (r_chipcnt == 5'd31) begin
        r_sr  <= '0;
        r_vld <= 1'b0;
      end else begin
        r_sr      <= {r_sr[30:0], 1'b0};
        r_chipcnt <= r_chipcnt + 5'd1;
      end
    end
  end

  assign chip_out       = r_sr[31];
  assign chip_out_valid = r_vld;
  assign overflow       = r_ovf;
  assign busy           = !w_empty || (r_state == SEND) || (r_bitcnt != 2'd0);

endmodule

// File: tb/tb_chip_spreading.sv
// Directed bench for chip_spreading: bit sequences with hand-picked expected
// symbols, chip streams checked against a rotate/invert model of the PN map.
module tb_chip_spreading;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic bit_in = 1'b0;
  logic bit_in_valid = 1'b0;
  logic chip_out, chip_out_valid, overflow, busy;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  chip_spreading #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_in_valid(bit_in_valid),
    .chip_out(chip_out), .chip_out_valid(chip_out_valid),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [23:0] bits;   // bit i is sent i-th
    int          nbits;
    int          nsym;
    logic [19:0] syms;   // expected symbol k in syms[4k+:4]
    int          lat;    // cycles from first bit drive to first valid chip
    int          ovf;    // cycle offset where overflow must rise, 0 = never
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Symbol 0 sequence, rotated right by 4*n for n=sym[2:0], odd chips inverted when sym[3].
  function automatic logic exp_chip(input logic [3:0] sym, input int i);
    logic [0:31] s0;
    int idx;
    s0  = 32'b11011001110000110101001000101110;
    idx = (i - 4 * int'(sym[2:0]) + 32) % 32;
    return s0[idx] ^ (sym[3] & ((i % 2) == 1));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drive_bits(input logic [23:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      bit_in_valid = 1'b1;
      bit_in       = bits[i];
    end
    @(negedge clk);
    bit_in_valid = 1'b0;
    bit_in       = 1'b0;
  endtask

  task automatic collect(input vec_t v, input int s);
    int t;
    logic ovf_ok, gap;
    logic [31:0] obs, e;
    logic [3:0] sym;
    t = 0; ovf_ok = 1'b1; gap = 1'b0;
    do begin
      @(negedge clk);
      t++;
    end while (!chip_out_valid && t < 20);
    chk("first_chip_latency", cyc - s, v.lat);
    if (!chip_out_valid) return;
    for (int k = 0; k < v.nsym; k++) begin
      sym = v.syms[4*k +: 4];
      for (int i = 0; i < 32; i++) begin
        if (!chip_out_valid) gap = 1'b1;
        obs[i] = chip_out;
        e[i]   = exp_chip(sym, i);
        if (overflow !== ((v.ovf != 0) && ((cyc - s) >= v.ovf))) ovf_ok = 1'b0;
        if (!(k == v.nsym - 1 && i == 31)) @(negedge clk);
      end
      chk($sformatf("sym%0d_chips", sym), obs, e);
    end
    chk("contiguous_valid", 32'(gap), 32'd0);
    @(negedge clk);
    chk("valid_after_last", 32'(chip_out_valid), 32'd0);
    chk("chip_after_last", 32'(chip_out), 32'd0);
    chk("busy_after_last", 32'(busy), 32'd0);
    chk("overflow_timing", 32'(ovf_ok), 32'd1);
    chk("overflow_final", 32'(overflow), 32'(v.ovf != 0));
  endtask

  task automatic run_vec(input vec_t v);
    int s;
    @(negedge clk);
    s = cyc;
    fork
      drive_bits(v.bits, v.nbits);
      collect(v, s);
    join
  endtask

  initial begin
    vec_t fresh;
    tbl[0] = '{24'h000000, 4,  1, 20'h00000, 5, 0};   // symbol 0
    tbl[1] = '{24'h000007, 8,  2, 20'h00007, 5, 0};   // byte 0x07: sym 7 then sym 0
    tbl[2] = '{24'h000008, 4,  1, 20'h00008, 5, 0};   // 0,0,0,1: sym 8
    tbl[3] = '{24'h000005, 3,  1, 20'h00005, 5, 0};   // 1,0,1 flushed: sym 5
    tbl[4] = '{24'hFFFFFF, 24, 5, 20'hFFFFF, 5, 24};  // 6th symbol dropped
    tbl[5] = '{24'h000016, 6,  2, 20'h00016, 5, 0};   // sym 6, then 2-bit flush sym 1
    tbl[6] = '{24'h0000A5, 8,  2, 20'h000A5, 5, 0};   // byte 0xA5: sym 5 then sym 10

    repeat (3) @(negedge clk);
    chk("reset_chip_out", 32'(chip_out), 32'd0);
    chk("reset_chip_valid", 32'(chip_out_valid), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    for (int n = 0; n < 7; n++) begin
      do_reset();
      run_vec(tbl[n]);
    end

    // Asynchronous reset while a symbol is being emitted and overflow is set.
    do_reset();
    @(negedge clk);
    drive_bits(24'hFFFFFF, 24);
    chk("pre_reset_valid", 32'(chip_out_valid), 32'd1);
    chk("pre_reset_overflow", 32'(overflow), 32'd1);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(chip_out_valid), 32'd0);
    chk("async_reset_chip", 32'(chip_out), 32'd0);
    chk("async_reset_overflow", 32'(overflow), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    #19 reset_n = 1'b1;
    fresh = '{24'h000002, 4, 1, 20'h00002, 5, 0};
    run_vec(fresh);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
